// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with a pixel-clock divider, registered
// blank/sync decode, line/frame strobes and a latched, acknowledgeable frame interrupt.
module video_timing_gen #(
    parameter int CLK_DIV      = 8,
    parameter int H_W          = 9,
    parameter int V_W          = 9,
    parameter int H_TOTAL      = 384,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 304,
    parameter int H_SYNC_LEN   = 32,
    parameter int V_TOTAL      = 264,
    parameter int V_ACTIVE     = 224,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_LEN   = 8,
    parameter int IRQ_LINE     = 224,
    parameter bit SYNC_POL     = 1'b0
) (
    input  logic           clk,
    input  logic           nRESET,
    input  logic           run,
    input  logic           int_ack_n,
    output logic           pix_ce,
    output logic [H_W-1:0] hcount,
    output logic [V_W-1:0] vcount,
    output logic           hblank,
    output logic           vblank,
    output logic           de,
    output logic           hsync,
    output logic           vsync,
    output logic           csync,
    output logic           line_start,
    output logic           frame_start,
    output logic           irq_n
);
    if (CLK_DIV < 1 || CLK_DIV > 256 || H_ACTIVE > H_TOTAL || V_ACTIVE > V_TOTAL ||
        H_SYNC_START + H_SYNC_LEN > H_TOTAL || V_SYNC_START + V_SYNC_LEN > V_TOTAL ||
        IRQ_LINE >= V_TOTAL || H_TOTAL > (1 << H_W) || V_TOTAL > (1 << V_W)) begin : g_bad_params
        $error("video_timing_gen: illegal timing parameters");
    end

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] IRQ_V    = V_W'(IRQ_LINE);

    typedef struct packed {
        logic hblank;
        logic vblank;
        logic de;
        logic hsync;
        logic vsync;
        logic csync;
    } dec_t;

    function automatic dec_t decode(input int h, input int v);
        dec_t d;
        logic hs, vs;
        hs = h >= H_SYNC_START && h < H_SYNC_START + H_SYNC_LEN;
        vs = v >= V_SYNC_START && v < V_SYNC_START + V_SYNC_LEN;
        d.hblank = h >= H_ACTIVE;
        d.vblank = v >= V_ACTIVE;
        d.de     = !d.hblank && !d.vblank;
        d.hsync  = hs ~^ SYNC_POL;
        d.vsync  = vs ~^ SYNC_POL;
        d.csync  = (hs || vs) ~^ SYNC_POL;
        return d;
    endfunction

    localparam dec_t DEC0 = decode(0, 0);

    logic [DW-1:0]  div_q, div_d;
    logic [H_W-1:0] hcount_q, hcount_d;
    logic [V_W-1:0] vcount_q, vcount_d;
    logic           pix_q, pix_d, line_q, line_d, frame_q, frame_d, irq_q, irq_d;
    logic           adv;
    dec_t           dec_q, dec_d;

    // pix_q marks the divider's last phase; the pixel advances on the edge that closes it
    always_comb begin
        adv      = run && pix_q;
        div_d    = run ? ((div_q == DIV_LAST) ? '0 : div_q + 1'b1) : div_q;
        pix_d    = run ? (div_d == DIV_LAST) : pix_q;
        hcount_d = adv ? ((hcount_q == H_LAST) ? '0 : hcount_q + 1'b1) : hcount_q;
        vcount_d = (adv && hcount_q == H_LAST) ? ((vcount_q == V_LAST) ? '0 : vcount_q + 1'b1) : vcount_q;
        line_d   = run ? (adv && hcount_d == '0) : line_q;
        frame_d  = run ? (adv && hcount_d == '0 && vcount_d == '0) : frame_q;
        irq_d    = (adv && hcount_d == '0 && vcount_d == IRQ_V) ? 1'b0 : (!int_ack_n ? 1'b1 : irq_q);
        dec_d    = decode(32'(hcount_d), 32'(vcount_d));
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            div_q    <= '0;
            pix_q    <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
            irq_q    <= 1'b1;
            dec_q    <= DEC0;
        end else begin
            div_q    <= div_d;
            pix_q    <= pix_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
            irq_q    <= irq_d;
            dec_q    <= dec_d;
        end
    end

    // strobes keep their state while frozen but are masked off by run
    assign pix_ce      = pix_q & run;
    assign line_start  = line_q & run;
    assign frame_start = frame_q & run;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign irq_n       = irq_q;
    assign hblank      = dec_q.hblank;
    assign vblank      = dec_q.vblank;
    assign de          = dec_q.de;
    assign hsync       = dec_q.hsync;
    assign vsync       = dec_q.vsync;
    assign csync       = dec_q.csync;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: small-raster bench; a reference model derived from elapsed enabled
// clocks feeds a scoreboard queue that a negedge monitor drains against the DUT.
module tb_video_timing_gen;
    localparam int N = 3, HT = 10, HA = 6, HSS = 7, HSL = 2;
    localparam int VT = 5, VA = 3, VSS = 3, VSL = 1, IRQ = 3;

    logic clk = 1'b0, nRESET = 1'b0, run = 1'b0, int_ack_n = 1'b1;
    logic pix_ce, hblank, vblank, de, hsync, vsync, csync, line_start, frame_start, irq_n;
    logic [3:0] hcount;
    logic [2:0] vcount;

    video_timing_gen #(
        .CLK_DIV(N), .H_W(4), .V_W(3), .H_TOTAL(HT), .H_ACTIVE(HA),
        .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .V_TOTAL(VT), .V_ACTIVE(VA),
        .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .IRQ_LINE(IRQ), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .nRESET(nRESET), .run(run), .int_ack_n(int_ack_n),
        .pix_ce(pix_ce), .hcount(hcount), .vcount(vcount),
        .hblank(hblank), .vblank(vblank), .de(de),
        .hsync(hsync), .vsync(vsync), .csync(csync),
        .line_start(line_start), .frame_start(frame_start), .irq_n(irq_n)
    );

    always #5 clk = ~clk;

    logic [16:0] exp_q[$];
    int    t_m = 0;
    bit    irq_m = 1'b1;
    int    checks = 0, fails = 0;
    string phase = "reset";

    function automatic int cur_h(input int tt);
        return (tt / N) % HT;
    endfunction

    function automatic int cur_v(input int tt);
        return (tt / N / HT) % VT;
    endfunction

    // expected outputs after tt enabled clocks since reset
    function automatic logic [16:0] model_vec(input int tt, input bit r, input bit irq);
        int h, v;
        bit pc, ls, fs, hs, vs;
        h  = cur_h(tt);
        v  = cur_v(tt);
        pc = r && (tt % N == N - 1);
        ls = r && tt > 0 && (tt % N == 0) && h == 0;
        fs = ls && v == 0;
        hs = !(h >= HSS && h < HSS + HSL);
        vs = !(v >= VSS && v < VSS + VSL);
        return {pc, 4'(h), 3'(v), h >= HA, v >= VA, (h < HA) && (v < VA), hs, vs, hs && vs, ls, fs, irq};
    endfunction

    // one clock: model sees the edge, then new inputs, optional async reset at +3, then expectation
    task automatic cycle(input bit r, input bit ack, input bit rn);
        @(posedge clk);
        if (nRESET) begin
            if (run) t_m++;
            if (run && t_m % N == 0 && cur_h(t_m) == 0 && cur_v(t_m) == IRQ) irq_m = 1'b0;
            else if (!int_ack_n) irq_m = 1'b1;
        end
        #1;
        run = r;
        int_ack_n = ack;
        #2;
        nRESET = rn;
        if (!rn) begin
            t_m = 0;
            irq_m = 1'b1;
        end
        #1;
        exp_q.push_back(model_vec(t_m, run, irq_m));
    endtask

    task automatic run_until(input int h, input int v);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (cur_h(t_m) == h && cur_v(t_m) == v && t_m % N == 0) begin
                hit = 1'b1;
                break;
            end
            cycle(1'b1, 1'b1, 1'b1);
        end
        if (!hit) begin
            checks++;
            fails++;
            $display("FAIL %s: position (%0d,%0d) not reached within 1000 clks", phase, h, v);
        end
    endtask

    initial begin : monitor
        logic [16:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pix_ce, hcount, vcount, hblank, vblank, de, hsync, vsync, csync,
                     line_start, frame_start, irq_n};
                checks++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL %s: outputs got %05h required %05h (model h=%0d v=%0d t=%0d)",
                             phase, a, e, cur_h(t_m), cur_v(t_m), t_m);
                end
            end
        end
    end

    initial begin
        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        phase = "free_run";
        repeat (2 * HT * VT * N + 20) cycle(1'b1, 1'b1, 1'b1);
        phase = "ack_pulse";
        cycle(1'b1, 1'b0, 1'b1);
        repeat (5) cycle(1'b1, 1'b1, 1'b1);
        phase = "random";
        repeat (1500) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 1'b1);
        phase = "freeze";
        run_until(5, 1);
        repeat (17) cycle(1'b0, 1'b1, 1'b1);
        repeat (3 * HT * N) cycle(1'b1, 1'b1, 1'b1);
        phase = "ack_vs_set";
        run_until(HT - 1, IRQ - 1);
        repeat (N + 3) cycle(1'b1, 1'b0, 1'b1);
        repeat (10) cycle(1'b1, 1'b1, 1'b1);
        phase = "mid_reset";
        run_until(4, 1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (HT * N * 2) cycle(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
